// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the three requester buses, the RAM port and the status flags.
// Latency: none; wires only.
// Backpressure: none; the arbiter holds requesters off through its acks and core_stall.
// Ports: slave modport = arbiter side, master modport = requesters + RAM side.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic [DW-1:0] ld_rdata;
  logic          ld_ack;
  logic          ld_mode;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  logic          core_stall;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, ld_mode, mem_q,
    output if_rdata, if_ack, d_rdata, d_ack, ld_rdata, ld_ack,
           mem_addr, mem_wdata, mem_rden, mem_wren, core_stall, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, ld_mode, mem_q,
    input  if_rdata, if_ack, d_rdata, d_ack, ld_rdata, ld_ack,
           mem_addr, mem_wdata, mem_rden, mem_wren, core_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction fetch, data access and loader.
// Latency: read ack 2+RD_LAT cycles after the request-sampling edge, write ack after 2; one IDLE cycle between accesses.
// Backpressure: level requests wait until granted (core_stall flags pending core requests); ld_mode holds off core grants.
// Ports: clk_i, rst_i (async active-high); arb_io (slave modport) carries requester buses, RAM port, core_stall, busy.
module mem_port_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave arb_io
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

  localparam logic [1:0] SRC_IF = 2'd0;
  localparam logic [1:0] SRC_D  = 2'd1;
  localparam logic [1:0] SRC_LD = 2'd2;
  localparam logic [1:0] LAT    = 2'(RD_LAT);

  state_e        state_q, state_d;
  logic [1:0]    src_q, src_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rr_q, rr_d;      // 1: D wins an IF/D tie (IF was served last)
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] ld_rdata_q, ld_rdata_d;

  logic mem_rden_c, mem_wren_c, if_ack_c, d_ack_c, ld_ack_c;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      src_q      <= SRC_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      ld_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  // Next-state and datapath latch logic
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    ld_rdata_d = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_io.ld_req) begin
          state_d = ISSUE;
          src_d   = SRC_LD;
          we_d    = arb_io.ld_we;
          addr_d  = arb_io.ld_addr;
          wdata_d = arb_io.ld_wdata;
        end else if (!arb_io.ld_mode && (arb_io.if_req || arb_io.d_req)) begin
          state_d = ISSUE;
          if (arb_io.if_req && (!arb_io.d_req || !rr_q)) begin
            src_d   = SRC_IF;
            we_d    = 1'b0;
            addr_d  = arb_io.if_addr;
            wdata_d = '0;
            rr_d    = 1'b1;
          end else begin
            src_d   = SRC_D;
            we_d    = arb_io.d_we;
            addr_d  = arb_io.d_addr;
            wdata_d = arb_io.d_wdata;
            rr_d    = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          // mem_q is valid in this last WAIT cycle
          state_d = DONE;
          case (src_q)
            SRC_IF:  if_rdata_d = arb_io.mem_q;
            SRC_D:   d_rdata_d  = arb_io.mem_q;
            default: ld_rdata_d = arb_io.mem_q;
          endcase
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_rden_c = 1'b0;
    mem_wren_c = 1'b0;
    if_ack_c   = 1'b0;
    d_ack_c    = 1'b0;
    ld_ack_c   = 1'b0;
    if (state_q == ISSUE) begin
      mem_rden_c = ~we_q;
      mem_wren_c = we_q;
    end
    if (state_q == DONE) begin
      if_ack_c = (src_q == SRC_IF);
      d_ack_c  = (src_q == SRC_D);
      ld_ack_c = (src_q == SRC_LD);
    end
  end

  assign arb_io.mem_rden   = mem_rden_c;
  assign arb_io.mem_wren   = mem_wren_c;
  assign arb_io.mem_addr   = addr_q;
  assign arb_io.mem_wdata  = wdata_q;
  assign arb_io.if_ack     = if_ack_c;
  assign arb_io.d_ack      = d_ack_c;
  assign arb_io.ld_ack     = ld_ack_c;
  assign arb_io.if_rdata   = if_rdata_q;
  assign arb_io.d_rdata    = d_rdata_q;
  assign arb_io.ld_rdata   = ld_rdata_q;
  assign arb_io.busy       = (state_q != IDLE);
  assign arb_io.core_stall = (arb_io.if_req & ~if_ack_c) | (arb_io.d_req & ~d_ack_c);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle-by-cycle vectors against a RD_LAT=1 arbiter, plus latency and reset sequences.
// Latency: RD_LAT=1 and RD_LAT=3 instances, each with its own synchronous RAM model.
// Backpressure: requesters are driven as level requests dropped in the ack cycle.
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .arb_io(b1));
  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .arb_io(b3));

  // RAM models: data appears RD_LAT cycles after the rden cycle, 16'hDEAD otherwise.
  logic [15:0] ram1 [512];
  logic [15:0] ram3 [512];
  logic [15:0] q1, p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) ram1[i] <= 16'h0000;
      ram1[9'h010] <= 16'hBEEF;
      ram1[9'h011] <= 16'hCAFE;
      q1 <= 16'hDEAD;
    end else begin
      if (b1.mem_wren) ram1[b1.mem_addr] <= b1.mem_wdata;
      q1 <= b1.mem_rden ? ram1[b1.mem_addr] : 16'hDEAD;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) ram3[i] <= 16'h0000;
      ram3[9'h010] <= 16'hBEEF;
      p3_0 <= 16'hDEAD;
      p3_1 <= 16'hDEAD;
      p3_2 <= 16'hDEAD;
    end else begin
      if (b3.mem_wren) ram3[b3.mem_addr] <= b3.mem_wdata;
      p3_0 <= b3.mem_rden ? ram3[b3.mem_addr] : 16'hDEAD;
      p3_1 <= p3_0;
      p3_2 <= p3_1;
    end
  end

  assign b1.mem_q = q1;
  assign b3.mem_q = p3_2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ctl = {mem_rden, mem_wren, if_ack, d_ack, ld_ack, core_stall, busy}
  typedef struct {
    logic        ifr;  logic [8:0] ifa;
    logic        dr;   logic       dwe;  logic [8:0] da;  logic [15:0] dwd;
    logic        lr;   logic       lwe;  logic [8:0] la;  logic [15:0] lwd;
    logic        lm;
    logic [6:0]  ctl;  logic [8:0] ma;   logic [15:0] mwd;
    logic [15:0] ifrd; logic [15:0] drd; logic [15:0] ldrd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ifr, input logic [8:0] ifa,
                     input logic dr, input logic dwe, input logic [8:0] da, input logic [15:0] dwd,
                     input logic lr, input logic lwe, input logic [8:0] la, input logic [15:0] lwd,
                     input logic lm, input logic [6:0] ctl, input logic [8:0] ma, input logic [15:0] mwd,
                     input logic [15:0] ifrd, input logic [15:0] drd, input logic [15:0] ldrd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.lr = lr; v.lwe = lwe; v.la = la; v.lwd = lwd; v.lm = lm;
    v.ctl = ctl; v.ma = ma; v.mwd = mwd; v.ifrd = ifrd; v.drd = drd; v.ldrd = ldrd;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b1.ld_req = 0; b1.ld_we = 0; b1.ld_addr = '0; b1.ld_wdata = '0; b1.ld_mode = 0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    b3.ld_req = 0; b3.ld_we = 0; b3.ld_addr = '0; b3.ld_wdata = '0; b3.ld_mode = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [79:0] act, exp;

  initial begin
    idle_inputs();

    // Single IF read of 0x010
    add(1,9'h010, 0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'h0000,16'h0000,16'h0000);
    add(1,9'h010, 0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b1000011,9'h010,16'h0000, 16'h0000,16'h0000,16'h0000);
    add(1,9'h010, 0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'h0000,16'h0000,16'h0000);
    add(1,9'h010, 0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0010001,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 0,0,9'h000,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000000,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    // D write 0x1FF=0x1234, inputs changed during ISSUE
    add(0,9'h010, 1,1,9'h1FF,16'h1234, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 1,1,9'h0AA,16'h5555, 0,0,9'h000,16'h0000, 0, 7'b0100011,9'h1FF,16'h1234, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 1,1,9'h0AA,16'h5555, 0,0,9'h000,16'h0000, 0, 7'b0001001,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 0,1,9'h0AA,16'h5555, 0,0,9'h000,16'h0000, 0, 7'b0000000,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    // D read back of 0x1FF
    add(0,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b1000011,9'h1FF,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'hBEEF,16'h0000,16'h0000);
    add(0,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0001001,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(0,9'h010, 0,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000000,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    // Round-robin with IF and D held high: IF, D, IF, D
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b1000011,9'h010,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0010011,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b1000011,9'h1FF,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h010, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0001011,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b1000011,9'h011,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'hBEEF,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h1FF,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0010011,9'h000,16'h0000, 16'hCAFE,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h010,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'hCAFE,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h010,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b1000011,9'h010,16'h0000, 16'hCAFE,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h010,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'hCAFE,16'h1234,16'h0000);
    add(1,9'h011, 1,0,9'h010,16'h0000, 0,0,9'h000,16'h0000, 0, 7'b0001011,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    // Loader first, then ld_mode=1 writes 0x000..0x003 while IF waits
    add(1,9'h000, 1,0,9'h1FF,16'h0000, 1,1,9'h000,16'h0001, 1, 7'b0000010,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h000,16'h0001, 1, 7'b0100011,9'h000,16'h0001, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h000,16'h0001, 1, 7'b0000111,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h001,16'h0002, 1, 7'b0000010,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h001,16'h0002, 1, 7'b0100011,9'h001,16'h0002, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h001,16'h0002, 1, 7'b0000111,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h002,16'h0003, 1, 7'b0000010,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h002,16'h0003, 1, 7'b0100011,9'h002,16'h0003, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h002,16'h0003, 1, 7'b0000111,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h003,16'h0004, 1, 7'b0000010,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h003,16'h0004, 1, 7'b0100011,9'h003,16'h0004, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 1,1,9'h003,16'h0004, 1, 7'b0000111,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    // ld_mode dropped: IF finally reads 0x0001 from 0x000
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 0,1,9'h003,16'h0004, 0, 7'b0000010,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 0,1,9'h003,16'h0004, 0, 7'b1000011,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 0,1,9'h003,16'h0004, 0, 7'b0000011,9'h000,16'h0000, 16'hCAFE,16'hBEEF,16'h0000);
    add(1,9'h000, 0,0,9'h1FF,16'h0000, 0,1,9'h003,16'h0004, 0, 7'b0010001,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0000);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 0,1,9'h003,16'h0004, 0, 7'b0000000,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0000);
    // Loader read of 0x003
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 1,0,9'h003,16'h0000, 0, 7'b0000000,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0000);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 1,0,9'h003,16'h0000, 0, 7'b1000001,9'h003,16'h0000, 16'h0001,16'hBEEF,16'h0000);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 1,0,9'h003,16'h0000, 0, 7'b0000001,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0000);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 1,0,9'h003,16'h0000, 0, 7'b0000101,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0004);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b0000000,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0004);
    // D read, req dropped in ISSUE and ld_mode rising mid-access: still completes
    add(0,9'h000, 1,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0004);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 1, 7'b1000001,9'h1FF,16'h0000, 16'h0001,16'hBEEF,16'h0004);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 1, 7'b0000001,9'h000,16'h0000, 16'h0001,16'hBEEF,16'h0004);
    add(0,9'h000, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 1, 7'b0001001,9'h000,16'h0000, 16'h0001,16'h1234,16'h0004);
    // IF blocked while ld_mode=1, granted once it drops
    add(1,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 1, 7'b0000010,9'h000,16'h0000, 16'h0001,16'h1234,16'h0004);
    add(1,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 1, 7'b0000010,9'h000,16'h0000, 16'h0001,16'h1234,16'h0004);
    add(1,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b0000010,9'h000,16'h0000, 16'h0001,16'h1234,16'h0004);
    add(1,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b1000011,9'h011,16'h0000, 16'h0001,16'h1234,16'h0004);
    add(1,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b0000011,9'h000,16'h0000, 16'h0001,16'h1234,16'h0004);
    add(1,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b0010001,9'h000,16'h0000, 16'hCAFE,16'h1234,16'h0004);
    add(0,9'h011, 0,0,9'h1FF,16'h0000, 0,0,9'h003,16'h0000, 0, 7'b0000000,9'h000,16'h0000, 16'hCAFE,16'h1234,16'h0004);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state_lat1", 80'({b1.mem_rden, b1.mem_wren, b1.if_ack, b1.d_ack, b1.ld_ack, b1.core_stall, b1.busy,
                                   b1.mem_addr, b1.mem_wdata, b1.if_rdata, b1.d_rdata, b1.ld_rdata}), 80'h0);
    check("reset_state_lat3", 80'({b3.mem_rden, b3.mem_wren, b3.if_ack, b3.d_ack, b3.ld_ack, b3.core_stall, b3.busy,
                                   b3.mem_addr, b3.mem_wdata, b3.if_rdata, b3.d_rdata, b3.ld_rdata}), 80'h0);
    rst = 1'b0;

    // Vector table on the RD_LAT=1 instance; one row per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      b1.if_req = vecs[i].ifr; b1.if_addr = vecs[i].ifa;
      b1.d_req = vecs[i].dr; b1.d_we = vecs[i].dwe; b1.d_addr = vecs[i].da; b1.d_wdata = vecs[i].dwd;
      b1.ld_req = vecs[i].lr; b1.ld_we = vecs[i].lwe; b1.ld_addr = vecs[i].la; b1.ld_wdata = vecs[i].lwd;
      b1.ld_mode = vecs[i].lm;
      #1;
      exp = {vecs[i].ctl,
             (vecs[i].ctl[6] | vecs[i].ctl[5]) ? vecs[i].ma : 9'h000,
             vecs[i].ctl[5] ? vecs[i].mwd : 16'h0000,
             vecs[i].ifrd, vecs[i].drd, vecs[i].ldrd};
      act = {b1.mem_rden, b1.mem_wren, b1.if_ack, b1.d_ack, b1.ld_ack, b1.core_stall, b1.busy,
             (vecs[i].ctl[6] | vecs[i].ctl[5]) ? b1.mem_addr : 9'h000,
             vecs[i].ctl[5] ? b1.mem_wdata : 16'h0000,
             b1.if_rdata, b1.d_rdata, b1.ld_rdata};
      check($sformatf("vec%0d", i), act, exp);
    end
    // The address presented after the grant must not have been written
    check("no_write_0aa", 80'(ram1[9'h0AA]), 80'h0);

    // RD_LAT=3: rden in cycle 1, ack with 0xBEEF in cycle 5
    @(negedge clk);
    b3.if_req = 1'b1;
    b3.if_addr = 9'h010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("lat3_cycle%0d", c), 80'({b3.mem_rden, b3.if_ack}), 80'({c == 1, c == 5}));
      if (c == 5) check("lat3_rdata", 80'(b3.if_rdata), 80'h0BEEF);
      if (b3.if_ack) b3.if_req = 1'b0;
    end
    b3.if_req = 1'b0;

    // Reset in the WAIT cycle of an IF read: everything clears, no ack follows
    @(negedge clk);
    b1.if_req = 1'b1;
    b1.if_addr = 9'h010;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_pre_wait", 80'({b1.mem_rden, b1.busy, b1.if_ack}), 80'b010);
    #1;
    rst = 1'b1;
    b1.if_req = 1'b0;
    #1;
    check("rst_mid_ctl", 80'({b1.mem_rden, b1.mem_wren, b1.if_ack, b1.d_ack, b1.ld_ack, b1.busy}), 80'h0);
    check("rst_mid_data", 80'({b1.if_rdata, b1.d_rdata, b1.ld_rdata, b1.mem_addr, b1.mem_wdata}), 80'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_no_ack%0d", c), 80'({b1.if_ack, b1.d_ack, b1.ld_ack, b1.busy, b1.mem_rden, b1.if_rdata}), 80'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between three requesters:
  - core instruction fetch (IF)
  - core data access (D)
  - external program loader (LD)
- Sits between the processor core's memory enables and the RAM IP. It replaces separate instruction and data memories with one unified memory.
- Sequences each access: grant, issue, wait for read latency, acknowledge. It also produces a stall indication for the core state machine.

Parameters:
- AW, 9, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency: cycles from the rden cycle to valid mem_q. Legal range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request, level.
- d_we  in  1  1=write, 0=read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data.
- d_ack  out  1  completion pulse.
- ld_req  in  1  loader request, level.
- ld_we  in  1  1=write, 0=read.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_rdata  out  DW  loader read data.
- ld_ack  out  1  completion pulse.
- ld_mode  in  1  1 blocks all core grants (program download).
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DW  RAM read data.
- core_stall  out  1  IF or D request pending and not yet acked.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate) clears everything:
  - state=IDLE; all acks, mem_rden and mem_wren = 0.
  - mem_addr, mem_wdata and all *_rdata = 0.
  - Round-robin pointer = IF-first.
  - In-flight access is abandoned and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitration happens on the rising edge. Priority:
  1. ld_req has absolute priority.
  2. If ld_mode=1, IF and D are never granted.
  3. Otherwise IF vs D is round-robin. The last-served of the pair loses a tie. Pointer updates only when IF or D is granted.
- On grant, register the winner id and latch addr/we/wdata. Later changes to the requester's inputs are ignored. Go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr/mem_wdata come from the latch.
  - Write: mem_wren=1, next state DONE.
  - Read: mem_rden=1, next state WAIT with counter=RD_LAT.
  - IF is always a read.
- WAIT: lasts RD_LAT cycles. On the edge ending the last WAIT cycle, capture mem_q into the winner's *_rdata. Then go to DONE.
- DONE (1 cycle):
  - The winner's *_ack=1.
  - *_rdata is valid and held until that requester's next read completes.
  - Next state IDLE. At most one ack per cycle.
- Latency, counted from the request-sampling edge:
  - Read: ack in cycle 2+RD_LAT.
  - Write: ack in cycle 2.
  - One IDLE cycle always separates back-to-back accesses.
- Requester rule: drop req by the edge ending the ack cycle. A req still high when sampled in IDLE is a new request.
- Req dropped before ack: the access still completes and ack still pulses.
- mem_rden/mem_wren are never high simultaneously and never high outside ISSUE.
- mem_addr holds its last value when idle.
- core_stall = (if_req & ~if_ack) | (d_req & ~d_ack). Combinational.
- ld_mode rising mid-access: the current core access completes normally. Blocking applies from the next IDLE arbitration.

Test Plan:
- Reset check: reset pulse mid-read (state WAIT) -> mem_rden=0, busy=0 and all acks 0 immediately. No ack follows. if_rdata=0.
- Single read, RD_LAT=1: RAM[0x010]=0xBEEF; if_req with if_addr=0x010 sampled at edge 0 -> mem_rden=1 in cycle 1, if_ack=1 and if_rdata=0xBEEF in cycle 3. Repeat with RD_LAT=3 -> ack in cycle 5.
- Write then read: d_we=1, d_addr=0x1FF, d_wdata=0x1234 -> mem_wren=1 in cycle 1, d_ack in cycle 2. d_we=0 read of 0x1FF -> d_rdata=0x1234. Address wrap is not applicable; 0x1FF is the top address.
- Round-robin: if_req and d_req held high continuously -> grant order IF, D, IF, D. Each ack is separated by an IDLE cycle, and core_stall=1 for the non-served requester.
- Loader priority and ld_mode: ld_req, if_req and d_req simultaneous -> LD served first. Then with ld_mode=1, 4 loader writes to 0x000..0x003 (0x0001..0x0004) complete while if_req stays unacked with core_stall=1. Dropping ld_mode -> IF granted and reads 0x0001 from 0x000.
- Input change after grant: change d_addr/d_wdata during ISSUE -> the original latched address and data are written.
